// File: rtl/dice_roll_gen.sv
// rtl/dice_roll_gen.sv - dice-roll source for the 7-segment dice display
//
// Purpose:
//   A free-running 16-bit Fibonacci LFSR supplies entropy. A rising edge on
//   roll_in starts a tumbling animation of ROLL_TICKS display updates, each
//   TICK_DIV cycles apart. The LFSR low byte is then reduced modulo the
//   latched die size by repeated subtraction. The face value 1..20 is
//   presented as a digit plus decimal-point flag.
//
// Ports:
//   clk           in   1  clock
//   reset         in   1  synchronous, active-high reset
//   roll_in       in   1  roll request level (synchronized/debounced upstream)
//   sides_sel     in   3  0=d2 1=d4 2=d6 3=d8 4=d10 5=d12 6=d20 7=d16
//   disp_digit    out  4  digit 0..9 for the segment decoder
//   disp_dp       out  1  decimal point for the segment decoder
//   result        out  5  final face value 1..20, 0 before the first roll
//   result_valid  out  1  one-cycle pulse in the first SHOW cycle
//   busy          out  1  high while rolling or reducing

module dice_roll_gen #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          TICK_DIV   = 2000000,
  parameter int          ROLL_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_in,
  input  logic [2:0] sides_sel,
  output logic [3:0] disp_digit,
  output logic       disp_dp,
  output logic [4:0] result,
  output logic       result_valid,
  output logic       busy
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ROLL_W = $clog2(ROLL_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [ROLL_W-1:0] ROLL_FINAL = ROLL_W'(ROLL_TICKS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROLL   = 2'd1;
  localparam logic [1:0] S_REDUCE = 2'd2;
  localparam logic [1:0] S_SHOW   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              roll_in_d_q, roll_in_d_d;
  logic [4:0]        sides_q, sides_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [ROLL_W-1:0] roll_cnt_q, roll_cnt_d;
  logic [7:0]        r_q, r_d;
  logic [4:0]        result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic [3:0]        disp_digit_q, disp_digit_d;
  logic              disp_dp_q, disp_dp_d;
  logic              busy_q, busy_d;

  logic              roll_rise;
  logic              lfsr_fb;
  logic [ROLL_W-1:0] roll_cnt_inc;
  logic [4:0]        face;
  logic [4:0]        face_enc;

  // Die size for each select code; d16 sits at code 7 so d20 keeps code 6.
  function automatic logic [4:0] sides_decode(input logic [2:0] sel);
    logic [4:0] s;
    case (sel)
      3'd0:    s = 5'd2;
      3'd1:    s = 5'd4;
      3'd2:    s = 5'd6;
      3'd3:    s = 5'd8;
      3'd4:    s = 5'd10;
      3'd5:    s = 5'd12;
      3'd6:    s = 5'd20;
      default: s = 5'd16;
    endcase
    return s;
  endfunction

  // Face value to {dp, digit}. The decimal point marks the tens place for
  // 11..20; 10 is shown as a bare 0. The 4-bit subtraction wraps mod 16,
  // which gives the right digit for 16..19 as well as 11..15.
  function automatic logic [4:0] encode_face(input logic [4:0] v);
    logic [4:0] e;
    if (v >= 5'd20) begin
      e = {1'b1, 4'd0};
    end else if (v >= 5'd11) begin
      e = {1'b1, v[3:0] - 4'd10};
    end else if (v == 5'd10) begin
      e = 5'd0;
    end else begin
      e = {1'b0, v[3:0]};
    end
    return e;
  endfunction

  always_comb begin
    lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    roll_rise = roll_in & ~roll_in_d_q;
    roll_cnt_inc = roll_cnt_q + ROLL_W'(1);
    // r is always below the die size (max 20) when leaving REDUCE.
    face     = r_q[4:0] + 5'd1;
    face_enc = encode_face(face);

    state_d        = state_q;
    roll_in_d_d    = roll_in;
    sides_d        = sides_q;
    tick_cnt_d     = tick_cnt_q;
    roll_cnt_d     = roll_cnt_q;
    r_d            = r_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    disp_digit_d   = disp_digit_q;
    disp_dp_d      = disp_dp_q;

    // The all-zero lock-up state is unreachable from a nonzero seed, but
    // recovering from it keeps the entropy source alive regardless.
    if (lfsr_q == 16'd0) begin
      lfsr_d = LFSR_SEED;
    end else begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end

    case (state_q)
      S_IDLE, S_SHOW: begin
        if (roll_rise) begin
          state_d    = S_ROLL;
          sides_d    = sides_decode(sides_sel);
          tick_cnt_d = '0;
          roll_cnt_d = '0;
        end
      end

      S_ROLL: begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          roll_cnt_d = roll_cnt_inc;
          // Tumbling face: fold the low nibble into 0..9.
          disp_digit_d = (lfsr_q[3:0] > 4'd9) ? (lfsr_q[3:0] - 4'd10) : lfsr_q[3:0];
          disp_dp_d    = 1'b0;
          if (roll_cnt_inc == ROLL_FINAL) begin
            state_d = S_REDUCE;
            r_d     = lfsr_q[7:0];
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end

      S_REDUCE: begin
        // Modulo by repeated subtraction: one subtract per cycle.
        if (r_q >= {3'b000, sides_q}) begin
          r_d = r_q - {3'b000, sides_q};
        end else begin
          state_d        = S_SHOW;
          result_d       = face;
          result_valid_d = 1'b1;
          disp_dp_d      = face_enc[4];
          disp_digit_d   = face_enc[3:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ROLL) || (state_d == S_REDUCE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      lfsr_q         <= LFSR_SEED;
      roll_in_d_q    <= 1'b0;
      sides_q        <= 5'd2;
      tick_cnt_q     <= '0;
      roll_cnt_q     <= '0;
      r_q            <= 8'd0;
      result_q       <= 5'd0;
      result_valid_q <= 1'b0;
      disp_digit_q   <= 4'd0;
      disp_dp_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      roll_in_d_q    <= roll_in_d_d;
      sides_q        <= sides_d;
      tick_cnt_q     <= tick_cnt_d;
      roll_cnt_q     <= roll_cnt_d;
      r_q            <= r_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      disp_digit_q   <= disp_digit_d;
      disp_dp_q      <= disp_dp_d;
      busy_q         <= busy_d;
    end
  end

  assign disp_digit   = disp_digit_q;
  assign disp_dp      = disp_dp_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dice_roll_gen.sv
// tb/tb_dice_roll_gen.sv - scoreboard bench for dice_roll_gen

module tb_dice_roll_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int ANIM = 2 * 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       roll_in;
  logic [2:0] sides_sel;
  logic [3:0] disp_digit;
  logic       disp_dp;
  logic [4:0] result;
  logic       result_valid;
  logic       busy;

  always #5 clk = ~clk;

  dice_roll_gen #(
    .LFSR_SEED (SEED),
    .TICK_DIV  (2),
    .ROLL_TICKS(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .roll_in     (roll_in),
    .sides_sel   (sides_sel),
    .disp_digit  (disp_digit),
    .disp_dp     (disp_dp),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy)
  );

  typedef struct {
    int res;
    int blen;
    int sides;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int sides_tab[8] = '{2, 4, 6, 8, 10, 12, 20, 16};
  logic [15:0] lfsr_m;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    logic fb;
    fb = q[15] ^ q[13] ^ q[12] ^ q[10];
    if (q == 16'd0) return SEED;
    return {q[14:0], fb};
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] q, input int n);
    logic [15:0] x;
    x = q;
    for (int i = 0; i < n; i++) x = lfsr_step(x);
    return x;
  endfunction

  function automatic int exp_digit(input int v);
    if (v == 20 || v == 10) return 0;
    if (v > 10) return v - 10;
    return v;
  endfunction

  function automatic int exp_dp(input int v);
    return (v > 10) ? 1 : 0;
  endfunction

  always @(posedge clk) lfsr_m <= reset ? SEED : lfsr_step(lfsr_m);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: counts busy length and pops the scoreboard on each pulse.
  int run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      run = 0;
    end else if (busy === 1'b1) begin
      run++;
    end else begin
      if (result_valid !== 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(result_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), e.res);
          chk("busy_len", run, e.blen);
          chk("range", 32'(result >= 5'd1 && int'(result) <= e.sides), 1);
          chk("digit", 32'(disp_digit), exp_digit(e.res));
          chk("dp", 32'(disp_dp), exp_dp(e.res));
        end
      end
      run = 0;
    end
  end

  // Called at a negedge; the roll edge is sampled at the following posedge.
  task automatic start_roll(input logic [2:0] sel, input bit push, input int hold,
                            input logic [2:0] sel_after);
    logic [15:0] l6;
    int r;
    int s;
    sides_sel = sel;
    s = sides_tab[sel];
    l6 = adv(lfsr_m, ANIM);
    r = int'(l6[7:0]);
    if (push) sb.push_back('{r % s + 1, ANIM + r / s + 1, s});
    roll_in = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      sides_sel = sel_after;
    end
    roll_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("idle_timeout", 1, 0);
  endtask

  // Idle until the model predicts the wanted face (target != 0) or r >= min_r.
  task automatic wait_for(input logic [2:0] sel, input int target, input int min_r);
    logic [15:0] l6;
    int r;
    int s;
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    s = sides_tab[sel];
    while (!hit && n < 5000) begin
      l6 = adv(lfsr_m, ANIM);
      r = int'(l6[7:0]);
      hit = (target != 0) ? (r % s + 1 == target) : (r >= min_r);
      if (!hit) begin
        @(negedge clk);
        n++;
      end
    end
    if (!hit) chk("wait_for_timeout", 1, 0);
  endtask

  initial begin
    logic [15:0] l0;
    logic [15:0] l2;
    int targets[6] = '{10, 15, 20, 7, 1, 19};

    reset = 1'b1;
    roll_in = 1'b0;
    sides_sel = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_digit", 32'(disp_digit), 0);
    chk("rst_dp", 32'(disp_dp), 0);
    chk("rst_valid", 32'(result_valid), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {disp_digit, disp_dp, result, busy, result_valid}, 0);
    end

    // Single roll on a d6, with the first animation frame checked.
    l0 = lfsr_m;
    start_roll(3'd2, 1'b1, 1, 3'd2);
    @(negedge clk);
    @(negedge clk);
    l2 = adv(l0, 2);
    chk("anim_digit", 32'(disp_digit), exp_digit(int'(l2[3:0]) % 10));
    chk("anim_dp", 32'(disp_dp), 0);
    chk("anim_busy", 32'(busy), 1);
    wait_idle();

    // Encoding corner faces on a d20.
    foreach (targets[k]) begin
      wait_for(3'd6, targets[k], 0);
      start_roll(3'd6, 1'b1, 1, 3'd6);
      wait_idle();
    end

    // Back-to-back d20 rolls; each new roll starts in the first SHOW cycle.
    for (int i = 0; i < 200; i++) begin
      start_roll(3'd6, 1'b1, 1, 3'd6);
      wait_idle();
    end

    for (int sel = 0; sel < 8; sel++) begin
      start_roll(3'(sel), 1'b1, 1, 3'(sel));
      wait_idle();
    end

    // Extra edges during ROLL and during REDUCE are ignored.
    wait_for(3'd0, 0, 40);
    start_roll(3'd0, 1'b1, 1, 3'd0);
    repeat (2) @(negedge clk);
    roll_in = 1'b1;
    @(negedge clk);
    roll_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("in_reduce_busy", 32'(busy), 1);
    roll_in = 1'b1;
    @(negedge clk);
    roll_in = 1'b0;
    wait_idle();

    // Held roll_in gives one roll; select change mid-roll has no effect.
    start_roll(3'd1, 1'b1, 100, 3'd6);
    wait_idle();
    repeat (20) @(negedge clk);

    // Reset in the middle of REDUCE aborts the roll.
    wait_for(3'd0, 0, 64);
    start_roll(3'd0, 1'b0, 1, 3'd0);
    repeat (7) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_digit", 32'(disp_digit), 0);
    chk("abort_dp", 32'(disp_dp), 0);
    chk("abort_valid", 32'(result_valid), 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    // Result right after reset depends on the LFSR having reloaded its seed.
    start_roll(3'd6, 1'b1, 1, 3'd6);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
